// File: rtl/register_pkg.sv
// Shared definitions for the register slice and its reader: data width,
// default reader FIFO depth and the reader FSM state type.
package register_pkg;

  localparam int WIDTH        = 8;
  localparam int READER_DEPTH = 4;

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DRAIN} reader_state_e;

endpackage

// File: rtl/register_reader_fifo.sv
// Small synchronous FIFO used by register_reader to buffer captured words.
// DEPTH must be a power of two so the pointers wrap naturally.
module register_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/register_reader.sv
// Burst reader for the register slice: issues credit-limited read enables,
// captures slice output one cycle later and streams it out through a FIFO.
// Optional build macro REGISTER_READER_PARITY_EN adds an even-parity output m_par.
module register_reader
  import register_pkg::*;
#(
  parameter int WIDTH = register_pkg::WIDTH,
  parameter int DEPTH = READER_DEPTH,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
`ifdef REGISTER_READER_PARITY_EN
  output logic             m_par,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];

  localparam logic [1:0] S_IDLE  = RD_IDLE;
  localparam logic [1:0] S_FETCH = RD_FETCH;
  localparam logic [1:0] S_DRAIN = RD_DRAIN;

`ifdef REGISTER_READER_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif

  logic [1:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic [FW-1:0]    push_word;
  logic [FW-1:0]    head_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic             credit_ok;

  // Words already buffered plus the one still travelling from the slice
  // must leave room, otherwise the capture a cycle later would overflow.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign credit_ok = (occupancy < DEPTH_V) && !fifo_full;
  assign rd_en     = (state == S_FETCH) && (remaining != '0) && credit_ok;
  assign busy      = (state != S_IDLE);
  assign m_valid   = !fifo_empty;

`ifdef REGISTER_READER_PARITY_EN
  assign push_word = {^rd_data, rd_data};
  assign m_par     = head_word[WIDTH];
  assign m_data    = head_word[WIDTH-1:0];
`else
  assign push_word = rd_data;
  assign m_data    = head_word;
`endif

  register_reader_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_word),
    .pop       (m_ready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= rd_en;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              remaining <= burst_len;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (rd_en) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finished only once the last captured word has also left the FIFO.
          if (fifo_empty && !inflight) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_reader.sv
// Self-checking bench for register_reader: models the register slice and
// checks the output stream against a queue of words the slice emitted.
`timescale 1ns/1ps
module tb_register_reader;
  import register_pkg::*;

  localparam int W  = register_pkg::WIDTH;
  localparam int D  = READER_DEPTH;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] burst_len;
  logic          rd_en;
  logic [W-1:0]  rd_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
`ifdef REGISTER_READER_PARITY_EN
  logic          m_par;
`endif
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  register_reader #(.WIDTH(W), .DEPTH(D), .LEN_W(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .burst_len (burst_len),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
`ifdef REGISTER_READER_PARITY_EN
    .m_par     (m_par),
`endif
    .busy      (busy),
    .done      (done)
  );

  // Register slice model: outa takes the next source word on each enabled edge.
  logic [W-1:0] src_words [1024];
  logic [9:0]   slice_idx = '0;
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data   <= src_words[slice_idx];
      slice_idx <= slice_idx + 10'd1;
    end
  end

  logic [W-1:0] exp_q [$];
  int issue_idx = 0;
  int errors = 0, checks = 0;
  int cyc = 0, issued, popped, done_seen, busy_seen, busy_gap, done_busy;
  int first_rd_cyc, last_rd_cyc, last_pop_cyc, done_cyc, start_cyc;
  bit in_burst = 0;

  typedef struct {
    int len;
    int ready_pct;
    int exp_words;
  } vec_t;
  vec_t vecs [6];

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic observe();
    logic [W-1:0] exp;
    cyc++;
    if (rd_en) begin
      exp_q.push_back(src_words[issue_idx]);
      issue_idx = (issue_idx + 1) % 1024;
      issued++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      checks++;
      if (exp_q.size() > D) begin
        errors++;
        $display("[TB] FAIL credit: outstanding %0d, limit %0d", exp_q.size(), D);
      end
    end
    if (m_valid && m_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_pop", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        check_output("m_data", 32'(m_data), 32'(exp));
`ifdef REGISTER_READER_PARITY_EN
        check_output("m_par", 32'(m_par), 32'(^exp));
`endif
      end
      popped++;
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_seen++;
      done_cyc = cyc;
      if (busy) done_busy++;
    end
    if (busy) busy_seen++;
    if (in_burst && done_seen == 0 && !busy) busy_gap++;
  endtask

  task automatic tick();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int len);
    issued = 0; popped = 0; done_seen = 0; busy_seen = 0; busy_gap = 0; done_busy = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    burst_len = LW'(len);
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    in_burst = (len != 0);
  endtask

  task automatic wait_done(input int budget, input int ready_pct);
    int n = 0;
    while (done_seen == 0 && n < budget) begin
      m_ready = ($urandom_range(99) < ready_pct);
      tick();
      n++;
    end
    in_burst = 0;
    if (done_seen == 0) check_output("done_timeout", 0, 1);
  endtask

  task automatic run_burst(input int len, input int ready_pct, input int exp_words);
    apply_stimulus(len);
    wait_done(len * 20 + 50, ready_pct);
    tick();
    tick();
    check_output("issued", issued, exp_words);
    check_output("popped", popped, exp_words);
    check_output("done_count", done_seen, 1);
    check_output("leftover", exp_q.size(), 0);
    check_output("busy_gap", busy_gap, 0);
    check_output("busy_at_done", done_busy, 0);
    if (len == 0) check_output("busy_len0", busy_seen, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) src_words[i] = W'($urandom);
    vecs[0] = '{len: 1,   ready_pct: 100, exp_words: 1};
    vecs[1] = '{len: 4,   ready_pct: 100, exp_words: 4};
    vecs[2] = '{len: 5,   ready_pct: 50,  exp_words: 5};
    vecs[3] = '{len: 9,   ready_pct: 25,  exp_words: 9};
    vecs[4] = '{len: 0,   ready_pct: 100, exp_words: 0};
    vecs[5] = '{len: 255, ready_pct: 100, exp_words: 255};

    reset = 1'b1; start = 1'b0; burst_len = '0; m_ready = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check_output("rst_rd_en", 32'(rd_en), 0);
    check_output("rst_m_valid", 32'(m_valid), 0);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_done", 32'(done), 0);
    check_output("rst_m_data", 32'(m_data), 0);
    reset = 1'b0;

    // Directed: three words at full rate, known data.
    for (int k = 0; k < 3; k++) src_words[(issue_idx + k) % 1024] = W'(8'hA1 + k);
    m_ready = 1'b1;
    apply_stimulus(3);
    wait_done(100, 100);
    check_output("t1_issued", issued, 3);
    check_output("t1_rd_consecutive", last_rd_cyc - first_rd_cyc, 2);
    check_output("t1_popped", popped, 3);
    // done rises on the edge after the final pop edge, seen two samples later.
    check_output("t1_done_after_pop", done_cyc - last_pop_cyc, 2);

    // Directed: back-pressure stalls fetch at FIFO capacity.
    m_ready = 1'b0;
    apply_stimulus(6);
    for (int k = 0; k < 12; k++) tick();
    check_output("t2_stall_issued", issued, D);
    check_output("t2_head_valid", 32'(m_valid), 1);
    check_output("t2_head_data", 32'(m_data), 32'(exp_q[0]));
    wait_done(100, 100);
    check_output("t2_issued", issued, 6);
    check_output("t2_popped", popped, 6);
    check_output("t2_done_count", done_seen, 1);

    // Directed: zero-length burst.
    apply_stimulus(0);
    wait_done(10, 100);
    check_output("t3_issued", issued, 0);
    check_output("t3_busy", busy_seen, 0);
    check_output("t3_done_next", done_cyc - start_cyc, 1);

    // Directed: a second start while busy is ignored.
    apply_stimulus(5);
    tick();
    tick();
    burst_len = LW'(9);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, 50);
    tick();
    check_output("t4_issued", issued, 5);
    check_output("t4_popped", popped, 5);
    check_output("t4_done_count", done_seen, 1);

    // Directed: reset in the middle of a fetch with words buffered.
    m_ready = 1'b0;
    apply_stimulus(8);
    for (int k = 0; k < 10 && issued < 3; k++) tick();
    in_burst = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    done_seen = 0;
    check_output("t5_m_valid", 32'(m_valid), 0);
    check_output("t5_rd_en", 32'(rd_en), 0);
    check_output("t5_busy", 32'(busy), 0);
    check_output("t5_done", 32'(done), 0);
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_output("t5_no_done", done_seen, 0);
    run_burst(3, 100, 3);

`ifdef REGISTER_READER_PARITY_EN
    src_words[issue_idx] = W'(8'h07);
    src_words[(issue_idx + 1) % 1024] = W'(8'h03);
    m_ready = 1'b0;
    apply_stimulus(2);
    for (int k = 0; k < 4; k++) tick();
    check_output("t6_par_07", 32'(m_par), 1);
    m_ready = 1'b1;
    tick();
    check_output("t6_par_03", 32'(m_par), 0);
    wait_done(50, 100);
`endif

    for (int v = 0; v < 6; v++) run_burst(vecs[v].len, vecs[v].ready_pct, vecs[v].exp_words);

    for (int r = 0; r < 10; r++) begin
      int len = $urandom_range(20);
      run_burst(len, $urandom_range(100, 20), len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
